// File: rtl/multi_channel_capture.sv
// Triggered multi-channel capture buffer: circular sample memory with a pre-trigger
// window, followed by a header-prefixed, oldest-first, one-sample-per-beat readout.
module multi_channel_capture #(
  parameter int unsigned             CHANNELS     = 4,
  parameter int unsigned             SAMPLE_WIDTH = 8,
  parameter int unsigned             DEPTH        = 1024,
  parameter logic [SAMPLE_WIDTH-1:0] SYNC_A       = 8'hFF,
  parameter logic [SAMPLE_WIDTH-1:0] SYNC_B       = 8'h00,
  localparam int unsigned            AW           = $clog2(DEPTH),
  localparam int unsigned            DW           = CHANNELS * SAMPLE_WIDTH
) (
  input  logic                    WriteClock,
  input  logic                    Reset,
  input  logic [DW-1:0]           DataIn,
  input  logic                    SampleValid,
  input  logic                    WriteStrobe,
  input  logic                    Arm,
  input  logic                    AutoRearm,
  input  logic [AW-1:0]           PreTrig,
  input  logic                    ReadEnable,
  output logic [SAMPLE_WIDTH-1:0] DataOut,
  output logic                    DataValid,
  output logic                    LastBeat,
  output logic                    FrameReady,
  output logic                    Armed,
  output logic [1:0]              State
);

  localparam int unsigned CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned NBEATS = DEPTH * CHANNELS + 2;
  localparam int unsigned KW     = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_READOUT = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              h_q;
  logic [AW-1:0]           wptr_q;
  logic [AW-1:0]           pt_q, pt_d;
  logic [AW-1:0]           fill_q, fill_d;
  logic [AW-1:0]           start_q, start_d;
  logic [AW-1:0]           t_q, t_d;
  logic [PW-1:0]           post_q, post_d;
  logic [KW-1:0]           k_q, k_d;
  logic [CW-1:0]           c_q, c_d;
  logic [SAMPLE_WIDTH-1:0] dout_q, dout_d;
  logic                    dv_q, dv_d;
  logic                    last_q, last_d;
  logic                    armed_q, fr_q;

  logic [DW-1:0]           mem [DEPTH];
  logic [DW-1:0]           rdata_q;

  logic                    trig_c;
  logic                    wr_c;
  logic                    load_c;
  logic [AW-1:0]           raddr_c;
  logic [PW-1:0]           post_len_c;
  logic [SAMPLE_WIDTH-1:0] chan_c;

  assign trig_c     = (h_q == 2'b01);
  assign wr_c       = SampleValid && ((state_q == S_ARMED) || (state_q == S_CAPTURE));
  assign post_len_c = PW'(DEPTH) - PW'(pt_q);
  assign chan_c     = rdata_q[int'(c_q) * SAMPLE_WIDTH +: SAMPLE_WIDTH];
  assign load_c     = (state_q == S_READOUT) && (!dv_q || ReadEnable) && (k_q < KW'(NBEATS));
  // Read address tracks the row the output register will need on the next load.
  assign raddr_c    = start_d + t_d;

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    fill_d  = fill_q;
    start_d = start_q;
    post_d  = post_q;
    k_d     = k_q;
    t_d     = t_q;
    c_d     = c_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (Arm) begin
          state_d = S_ARMED;
          pt_d    = PreTrig;
          fill_d  = '0;
        end
      end
      S_ARMED: begin
        if (trig_c && (fill_q == pt_q)) begin
          start_d = wptr_q - pt_q;
          post_d  = PW'(wr_c);
          if (wr_c && (post_len_c == PW'(1))) begin
            state_d = S_READOUT;
            k_d     = '0;
            t_d     = '0;
            c_d     = '0;
          end else begin
            state_d = S_CAPTURE;
          end
        end else if (Arm) begin
          pt_d   = PreTrig;
          fill_d = '0;
        end else if (wr_c && (fill_q != pt_q)) begin
          fill_d = fill_q + AW'(1);
        end
      end
      S_CAPTURE: begin
        if (wr_c) begin
          post_d = post_q + PW'(1);
          if (post_d == post_len_c) begin
            state_d = S_READOUT;
            k_d     = '0;
            t_d     = '0;
            c_d     = '0;
          end
        end
      end
      S_READOUT: begin
        if (dv_q && ReadEnable) begin
          dv_d   = 1'b0;
          last_d = 1'b0;
          if (last_q) begin
            if (AutoRearm) begin
              state_d = S_ARMED;
              pt_d    = PreTrig;
              fill_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        // Refill the output register whenever it is empty or being drained.
        if (load_c) begin
          dv_d   = 1'b1;
          last_d = (k_q == KW'(NBEATS - 1));
          k_d    = k_q + KW'(1);
          if (k_q == KW'(0)) begin
            dout_d = SYNC_A;
          end else if (k_q == KW'(1)) begin
            dout_d = SYNC_B;
          end else begin
            dout_d = chan_c;
            if (c_q == CW'(CHANNELS - 1)) begin
              c_d = '0;
              t_d = t_q + AW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge WriteClock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      wptr_q  <= '0;
      pt_q    <= '0;
      fill_q  <= '0;
      start_q <= '0;
      post_q  <= '0;
      k_q     <= '0;
      t_q     <= '0;
      c_q     <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      armed_q <= 1'b0;
      fr_q    <= 1'b0;
    end else begin
      h_q     <= {h_q[0], WriteStrobe};
      if (wr_c) begin
        wptr_q <= wptr_q + AW'(1);
      end
      state_q <= state_d;
      pt_q    <= pt_d;
      fill_q  <= fill_d;
      start_q <= start_d;
      post_q  <= post_d;
      k_q     <= k_d;
      t_q     <= t_d;
      c_q     <= c_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      armed_q <= (state_d == S_ARMED) && (fill_d == pt_d);
      fr_q    <= (state_d == S_READOUT);
    end
  end

  // Sample memory with registered read port; contents need no reset.
  always_ff @(posedge WriteClock) begin
    if (wr_c) begin
      mem[wptr_q] <= DataIn;
    end
    rdata_q <= mem[raddr_c];
  end

  assign DataOut    = dout_q;
  assign DataValid  = dv_q;
  assign LastBeat   = last_q;
  assign FrameReady = fr_q;
  assign Armed      = armed_q;
  assign State      = state_q;

endmodule

// File: tb/tb_multi_channel_capture.sv
// Randomised bench for multi_channel_capture: a queue-based frame model feeds a
// beat scoreboard that a negedge monitor drains on every handshake.
module tb_multi_channel_capture;

  localparam int unsigned CH     = 4;
  localparam int unsigned SW     = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned DW     = CH * SW;
  localparam int unsigned NBEATS = DEPTH * CH + 2;
  localparam logic [SW-1:0] SA   = 8'hFF;
  localparam logic [SW-1:0] SB   = 8'h00;

  logic          WriteClock;
  logic          Reset;
  logic [DW-1:0] DataIn;
  logic          SampleValid;
  logic          WriteStrobe;
  logic          Arm;
  logic          AutoRearm;
  logic [AW-1:0] PreTrig;
  logic          ReadEnable;
  logic [SW-1:0] DataOut;
  logic          DataValid;
  logic          LastBeat;
  logic          FrameReady;
  logic          Armed;
  logic [1:0]    State;

  multi_channel_capture #(
    .CHANNELS(CH), .SAMPLE_WIDTH(SW), .DEPTH(DEPTH), .SYNC_A(SA), .SYNC_B(SB)
  ) dut (
    .WriteClock(WriteClock), .Reset(Reset), .DataIn(DataIn), .SampleValid(SampleValid),
    .WriteStrobe(WriteStrobe), .Arm(Arm), .AutoRearm(AutoRearm), .PreTrig(PreTrig),
    .ReadEnable(ReadEnable), .DataOut(DataOut), .DataValid(DataValid), .LastBeat(LastBeat),
    .FrameReady(FrameReady), .Armed(Armed), .State(State)
  );

  initial WriteClock = 1'b0;
  always #5 WriteClock = ~WriteClock;

  typedef enum int {M_IDLE, M_ARMED, M_CAPT, M_READ} mode_e;
  typedef struct {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] hist[$];
  logic [DW-1:0] frame[$];
  mode_e         m_mode;
  int            pt;
  int            rem;
  int            read_cycles;
  int            m_frames;
  logic          ws_d1, ws_d2;
  logic          hold;
  logic [SW-1:0] hold_data;
  logic          hold_last;
  logic          xfer, ev, wr;
  beat_t         b;

  int checks   = 0;
  int failures = 0;

  int sv_pct, re_pct, ramp_t, ws_cnt;
  logic ramp, auto_ws;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] mode_code(input mode_e m);
    case (m)
      M_IDLE:  return 2'b00;
      M_ARMED: return 2'b01;
      M_CAPT:  return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic start_arm();
    m_mode = M_ARMED;
    pt     = int'(PreTrig);
    hist.delete();
  endtask

  // Frame complete: queue the header and every sample oldest-first, channel 0 first.
  task automatic finish_frame();
    logic [DW-1:0] row;
    sb.push_back('{SA, 1'b0});
    sb.push_back('{SB, 1'b0});
    for (int t = 0; t < int'(DEPTH); t++) begin
      row = frame[t];
      for (int c = 0; c < int'(CH); c++)
        sb.push_back('{row[c*SW +: SW], (t == int'(DEPTH) - 1) && (c == int'(CH) - 1)});
    end
    m_mode      = M_READ;
    rem         = NBEATS;
    read_cycles = 0;
  endtask

  // Monitor then model: outputs are checked against the model's view of the current
  // cycle, after which the model advances using the inputs of the coming edge.
  always @(negedge WriteClock) begin
    if (Reset) begin
      chk("rst_dataout", DataOut, 0);
      chk("rst_datavalid", DataValid, 0);
      chk("rst_lastbeat", LastBeat, 0);
      chk("rst_frameready", FrameReady, 0);
      chk("rst_armed", Armed, 0);
      chk("rst_state", State, 0);
      m_mode = M_IDLE;
      sb.delete();
      hist.delete();
      frame.delete();
      ws_d1 = 1'b0;
      ws_d2 = 1'b0;
      hold  = 1'b0;
    end else begin
      chk("state", State, mode_code(m_mode));
      chk("armed", Armed, (m_mode == M_ARMED) && (hist.size() >= pt));
      chk("frame_ready", FrameReady, m_mode == M_READ);
      chk("valid_outside_readout", DataValid && (m_mode != M_READ), 0);
      if (hold) begin
        chk("hold_valid", DataValid, 1);
        chk("hold_data", DataOut, hold_data);
        chk("hold_last", LastBeat, hold_last);
      end
      xfer = DataValid && ReadEnable;
      if (xfer) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", DataOut, 32'hDEAD);
        end else begin
          b = sb.pop_front();
          chk("beat_data", DataOut, b.data);
          chk("beat_last", LastBeat, b.last);
        end
      end
      hold      = DataValid && !ReadEnable;
      hold_data = DataOut;
      hold_last = LastBeat;

      ev = ws_d1 && !ws_d2;
      wr = SampleValid && ((m_mode == M_ARMED) || (m_mode == M_CAPT));
      case (m_mode)
        M_IDLE: if (Arm) start_arm();
        M_ARMED: begin
          if (ev && (hist.size() >= pt)) begin
            frame.delete();
            for (int i = hist.size() - pt; i < hist.size(); i++) frame.push_back(hist[i]);
            if (wr) frame.push_back(DataIn);
            m_mode = M_CAPT;
            if (frame.size() == int'(DEPTH)) finish_frame();
          end else if (Arm) begin
            start_arm();
          end else if (wr) begin
            hist.push_back(DataIn);
          end
        end
        M_CAPT: begin
          if (wr) frame.push_back(DataIn);
          if (frame.size() == int'(DEPTH)) finish_frame();
        end
        default: begin
          read_cycles++;
          if (xfer) begin
            rem--;
            if (rem == 0) begin
              m_frames++;
              if (re_pct == 100) chk("readout_cycles", read_cycles <= int'(NBEATS) + 2, 1);
              if (AutoRearm) start_arm();
              else m_mode = M_IDLE;
            end
          end
        end
      endcase
      ws_d2 = ws_d1;
      ws_d1 = WriteStrobe;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      SampleValid = ($urandom_range(99) < sv_pct);
      if (ramp) begin
        for (int c = 0; c < int'(CH); c++) DataIn[c*SW +: SW] = SW'(4 * ramp_t + c);
        if (SampleValid) ramp_t++;
      end else begin
        DataIn = $urandom;
      end
      ReadEnable = ($urandom_range(99) < re_pct);
      if (auto_ws) begin
        WriteStrobe = (m_mode == M_ARMED) && (ws_cnt % 4 == 0);
        ws_cnt++;
      end
      @(posedge WriteClock);
      #1;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while ((m_frames < target) && (n < budget)) begin
      tick(1);
      n++;
    end
    chk("frame_count", m_frames, target);
  endtask

  task automatic wait_mode(input mode_e target, input int budget);
    int n = 0;
    while ((m_mode != target) && (n < budget)) begin
      tick(1);
      n++;
    end
    chk("mode_reached", mode_code(m_mode), mode_code(target));
  endtask

  task automatic arm(input int p);
    PreTrig = AW'(p);
    Arm     = 1'b1;
    tick(1);
    Arm     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; DataIn = '0; SampleValid = 1'b0; WriteStrobe = 1'b0; Arm = 1'b0;
    AutoRearm = 1'b0; PreTrig = '0; ReadEnable = 1'b0;
    m_mode = M_IDLE; pt = 0; rem = 0; read_cycles = 0; m_frames = 0;
    ws_d1 = 1'b0; ws_d2 = 1'b0; hold = 1'b0;
    sv_pct = 100; re_pct = 100; ramp = 1'b1; ramp_t = 0; auto_ws = 1'b0; ws_cnt = 0;
    tick(3);
    Reset = 1'b0;
    tick(2);

    // Ramp frame, pre-trigger 4, trigger after 10 samples.
    arm(4);
    tick(10);
    WriteStrobe = 1'b1; tick(1); WriteStrobe = 1'b0;
    wait_frames(1, 500);

    // Zero pre-trigger, strobe rising together with the arm.
    PreTrig = '0; Arm = 1'b1; WriteStrobe = 1'b1; tick(1);
    Arm = 1'b0; tick(1); WriteStrobe = 1'b0;
    wait_frames(2, 500);

    // Early trigger discarded; second (held-high) trigger aligns the frame.
    arm(8);
    tick(3);
    WriteStrobe = 1'b1; tick(1); WriteStrobe = 1'b0;
    tick(5);
    WriteStrobe = 1'b1; tick(5); WriteStrobe = 1'b0;
    wait_frames(3, 500);

    // Random data, gaps and consumer back-pressure, including window extremes.
    ramp = 1'b0; sv_pct = 70; re_pct = 50;
    for (int k = 0; k < 4; k++) begin
      arm((k == 0) ? 15 : (k == 1) ? 0 : int'($urandom_range(15)));
      auto_ws = 1'b1;
      wait_frames(m_frames + 1, 3000);
      auto_ws = 1'b0;
      WriteStrobe = 1'b0;
    end

    // Auto-rearm across two frames.
    AutoRearm = 1'b1; sv_pct = 100; re_pct = 100;
    arm(5);
    auto_ws = 1'b1;
    wait_frames(m_frames + 1, 1000);
    chk("rearm_state", State, 2'b01);
    AutoRearm = 1'b0;
    wait_frames(m_frames + 1, 1000);
    auto_ws = 1'b0; WriteStrobe = 1'b0;
    chk("after_rearm_idle", State, 2'b00);

    // Reset mid-capture, then strobes while idle must not produce beats.
    arm(4);
    tick(6);
    WriteStrobe = 1'b1; tick(1); WriteStrobe = 1'b0;
    tick(5);
    chk("mid_capture_state", State, 2'b10);
    Reset = 1'b1; tick(2); Reset = 1'b0;
    re_pct = 50;
    tick(3); WriteStrobe = 1'b1; tick(2); WriteStrobe = 1'b0; tick(10);

    // Reset mid-readout, then one clean frame.
    arm(3);
    auto_ws = 1'b1;
    wait_mode(M_READ, 500);
    auto_ws = 1'b0; WriteStrobe = 1'b0;
    tick(10);
    Reset = 1'b1; tick(1); Reset = 1'b0;
    tick(10);
    arm(6);
    auto_ws = 1'b1;
    wait_frames(m_frames + 1, 3000);
    auto_ws = 1'b0; WriteStrobe = 1'b0;
    tick(4);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
